// File: rtl/vs_pkg.sv
// Shared SCI constants and writer FSM state encoding.
// Used by the volume SCI writer and its serializer.
package vs_pkg;

  localparam logic [7:0] SCI_OP_WRITE = 8'h02;
  localparam logic [7:0] SCI_OP_READ  = 8'h03;
  localparam logic [7:0] SCI_REG_VOL  = 8'h0B;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DREQ,
    SHIFT,
    HOLD
  } state_e;

endpackage

// File: rtl/vol_sci_writer_if.sv
// SCI bus bundle: arbiter handshake, decoder ready and serial lines.
// The writer is master; the player/decoder side is slave.
interface vol_sci_writer_if;

  logic BUS_REQ;
  logic BUS_GNT;
  logic DREQ;
  logic XCS;
  logic SCLK;
  logic MOSI;

  modport master (
    output BUS_REQ,
    output XCS,
    output SCLK,
    output MOSI,
    input  BUS_GNT,
    input  DREQ
  );

  modport slave (
    input  BUS_REQ,
    input  XCS,
    input  SCLK,
    input  MOSI,
    output BUS_GNT,
    output DREQ
  );

endinterface

// File: rtl/sci_shift32.sv
// Mode-0 32-bit serializer: SCLK divider, shift register, edge counter.
// done is asserted combinationally on the clock that makes the 32nd fall.
module sci_shift32
  import vs_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] frame,
  output logic        done,
  output logic        SCLK,
  output logic        MOSI
);

  logic        active;
  logic [7:0]  div;
  logic [5:0]  edges;
  logic [31:0] sreg;
  logic        tick;

  assign tick = active && (div == 8'(CLK_DIV - 1));
  assign done = tick && SCLK && (edges == 6'd63);
  assign MOSI = active & sreg[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      div    <= '0;
      edges  <= '0;
      sreg   <= '0;
      SCLK   <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      div    <= '0;
      edges  <= '0;
      sreg   <= frame;
      SCLK   <= 1'b0;
    end else if (active) begin
      if (tick) begin
        div   <= '0;
        SCLK  <= ~SCLK;
        edges <= edges + 6'd1;
        // data moves on the falling edge only
        if (SCLK) sreg <= {sreg[30:0], 1'b0};
        if (done) active <= 1'b0;
      end else begin
        div <= div + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vol_sci_writer.sv
// Writes changed volume values to the VS10xx SCI_VOL register.
// Owns the VOL synchronizer, LAST tracking and the transfer FSM.
module vol_sci_writer
  import vs_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter logic [7:0] SCI_ADDR = SCI_REG_VOL
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [15:0]       VOL,
  vol_sci_writer_if.master  sci,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [8:0] HOLD_LOW = 9'(CLK_DIV);
  localparam logic [8:0] HOLD_END = 9'(2 * CLK_DIV - 1);

  state_e      state;
  logic [15:0] s1;
  logic [15:0] s2;
  logic [15:0] last_q;
  logic [31:0] frame;
  logic [8:0]  hcnt;
  logic        done_q;
  logic        valid;
  logic        sh_start;
  logic        sh_done;
  logic        sh_sclk;
  logic        sh_mosi;

  assign valid    = (s2 == s1);
  assign sh_start = (state == WAIT_DREQ) && sci.DREQ;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      s1     <= '0;
      s2     <= '0;
      last_q <= '0;
      frame  <= '0;
      hcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      s1     <= VOL;
      s2     <= s1;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid && (s2 != last_q)) state <= REQ;
        end
        REQ: begin
          // value may have settled back to LAST while waiting: drop it
          if (sci.BUS_GNT && valid) begin
            if (s2 == last_q) begin
              state <= IDLE;
            end else begin
              frame  <= {SCI_OP_WRITE, SCI_ADDR, s2};
              last_q <= s2;
              state  <= WAIT_DREQ;
            end
          end
        end
        WAIT_DREQ: begin
          if (sci.DREQ) state <= SHIFT;
        end
        SHIFT: begin
          if (sh_done) begin
            hcnt  <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (hcnt == HOLD_END) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            hcnt <= hcnt + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sci_shift32 #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk   (CLK),
    .rst_n (RSTN),
    .start (sh_start),
    .frame (frame),
    .done  (sh_done),
    .SCLK  (sh_sclk),
    .MOSI  (sh_mosi)
  );

  assign sci.BUS_REQ = (state != IDLE);
  assign sci.XCS     = !((state == SHIFT) ||
                         ((state == HOLD) && (hcnt < HOLD_LOW)));
  assign sci.SCLK    = sh_sclk;
  assign sci.MOSI    = sh_mosi;
  assign BUSY        = (state != IDLE);
  assign DONE        = done_q;

endmodule

// File: tb/tb_vol_sci_writer.sv
// Directed bench for vol_sci_writer with CLK_DIV=4.
// A passive monitor decodes frames off the SCI lines.
module tb_vol_sci_writer;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [15:0] VOL;
  logic        BUSY;
  logic        DONE;

  int tests = 0;
  int fails = 0;

  vol_sci_writer_if sci ();

  vol_sci_writer #(
    .CLK_DIV  (4),
    .SCI_ADDR (8'h0B)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .VOL  (VOL),
    .sci  (sci),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  logic [31:0] frames[$];
  int          lows[$];
  int          nbs[$];
  int          done_cnt = 0;
  int          mosi_err = 0;
  int          cur_bits = 0;
  int          lowc = 0;
  logic [31:0] sh = '0;
  bit          in_frame = 0;
  bit          prev_sclk = 0;
  bit          done_prev = 0;
  bit          busy_after_done = 0;

  always @(negedge CLK) begin
    if (sci.XCS === 1'b0) begin
      if (!in_frame) begin
        in_frame = 1;
        sh = '0;
        cur_bits = 0;
        lowc = 0;
      end
      lowc++;
      if (sci.SCLK && !prev_sclk) begin
        sh = {sh[30:0], sci.MOSI};
        cur_bits++;
      end
    end else begin
      if (in_frame) begin
        frames.push_back(sh);
        lows.push_back(lowc);
        nbs.push_back(cur_bits);
        in_frame = 0;
      end
      if (sci.MOSI !== 1'b0) mosi_err++;
    end
    if (done_prev) busy_after_done = BUSY;
    done_prev = DONE;
    if (DONE) done_cnt++;
    prev_sclk = sci.SCLK;
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    frames.delete();
    lows.delete();
    nbs.delete();
    done_cnt = 0;
  endtask

  task automatic wait_frames(input int n, input int budget,
                             output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (frames.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    VOL = 16'h0000;
    sci.BUS_GNT = 1'b0;
    sci.DREQ = 1'b0;
    repeat (3) step();
    tests++;
    if ({sci.XCS, sci.SCLK, sci.MOSI, sci.BUS_REQ, BUSY, DONE} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 100000",
               {sci.XCS, sci.SCLK, sci.MOSI, sci.BUS_REQ, BUSY, DONE});
    end
    RSTN = 1'b1;
    sci.BUS_GNT = 1'b1;
    sci.DREQ = 1'b1;
    clear_mon();
    repeat (50) step();
    tests++;
    if (frames.size() != 0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL reset_zero_vol: frames %0d busy %b required 0 0",
               frames.size(), BUSY);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_mon();
    VOL = 16'h1010;
    wait_frames(1, 2000, ok);
    repeat (20) step();
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL single_timeout: no frame seen, required 1");
    end else begin
      tests++;
      if (frames[0] !== 32'h020B1010) begin
        fails++;
        $display("FAIL single_frame: got %h required 020b1010", frames[0]);
      end
      tests++;
      if (lows[0] != 260 || nbs[0] != 32) begin
        fails++;
        $display("FAIL single_timing: low %0d bits %0d required 260 32",
                 lows[0], nbs[0]);
      end
    end
    tests++;
    if (done_cnt != 1 || busy_after_done !== 1'b0) begin
      fails++;
      $display("FAIL single_done: pulses %0d busy_after %b required 1 0",
               done_cnt, busy_after_done);
    end
    tests++;
    if (dut.last_q !== 16'h1010 || sci.BUS_REQ !== 1'b0) begin
      fails++;
      $display("FAIL single_last: last %h req %b required 1010 0",
               dut.last_q, sci.BUS_REQ);
    end
  endtask

  task automatic test_grant();
    bit ok;
    int bad;
    clear_mon();
    sci.BUS_GNT = 1'b0;
    VOL = 16'h3333;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i >= 5 && (sci.BUS_REQ !== 1'b1 || sci.XCS !== 1'b1)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL grant_wait: bad cycles %0d required 0", bad);
    end
    sci.BUS_GNT = 1'b1;
    wait_frames(1, 2000, ok);
    repeat (20) step();
    tests++;
    if (!ok || frames[0] !== 32'h020B3333) begin
      fails++;
      $display("FAIL grant_frame: ok %b frame %h required 1 020b3333",
               ok, ok ? frames[0] : 32'h0);
    end
  endtask

  task automatic test_dreq();
    bit ok;
    int bad;
    clear_mon();
    sci.DREQ = 1'b0;
    VOL = 16'h4444;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i >= 5 && (sci.BUS_REQ !== 1'b1 || sci.XCS !== 1'b1)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL dreq_wait: bad cycles %0d required 0", bad);
    end
    sci.DREQ = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (sci.XCS === 1'b0) begin
        ok = 1;
        break;
      end
    end
    repeat (40) step();
    sci.DREQ = 1'b0;
    wait_frames(1, 2000, ok);
    tests++;
    if (!ok || frames[0] !== 32'h020B4444 || lows[0] != 260) begin
      fails++;
      $display("FAIL dreq_frame: ok %b frame %h low %0d required 1 020b4444 260",
               ok, ok ? frames[0] : 32'h0, ok ? lows[0] : 0);
    end
    sci.DREQ = 1'b1;
    repeat (20) step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    VOL = 16'h1010;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sci.XCS === 1'b0) begin
        ok = 1;
        break;
      end
    end
    repeat (20) step();
    VOL = 16'h2020;
    wait_frames(1, 2000, ok);
    for (int i = 0; i < 30 && done_cnt < 1; i++) step();
    step();
    tests++;
    if (busy_after_done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart: busy after done %b required 1",
               busy_after_done);
    end
    wait_frames(2, 2000, ok);
    repeat (20) step();
    tests++;
    if (!ok || frames[0] !== 32'h020B1010 || frames[1] !== 32'h020B2020) begin
      fails++;
      $display("FAIL b2b_frames: ok %b got %h %h required 020b1010 020b2020",
               ok, frames.size() > 0 ? frames[0] : 32'h0,
               frames.size() > 1 ? frames[1] : 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    VOL = 16'h5555;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (cur_bits == 12 && sci.XCS === 1'b0) begin
        ok = 1;
        break;
      end
    end
    RSTN = 1'b0;
    VOL = 16'h0000;
    #1;
    tests++;
    if (!ok || {sci.XCS, sci.SCLK, sci.MOSI, DONE} !== 4'b1000) begin
      fails++;
      $display("FAIL mid_reset: ok %b xcs/sclk/mosi/done %b required 1 1000",
               ok, {sci.XCS, sci.SCLK, sci.MOSI, DONE});
    end
    repeat (5) step();
    RSTN = 1'b1;
    repeat (200) step();
    tests++;
    if (frames.size() != 1 || done_cnt != 0) begin
      fails++;
      $display("FAIL mid_after: frames %0d done %0d required 1 0",
               frames.size(), done_cnt);
    end else begin
      tests++;
      if (nbs[0] != 12) begin
        fails++;
        $display("FAIL mid_bits: got %0d required 12", nbs[0]);
      end
    end
  endtask

  task automatic test_repeat();
    bit ok;
    clear_mon();
    VOL = 16'hF0F0;
    wait_frames(1, 2000, ok);
    repeat (20) step();
    VOL = 16'h1234;
    step();
    VOL = 16'hF0F0;
    repeat (300) step();
    tests++;
    if (!ok || frames.size() != 1 || frames[0] !== 32'h020BF0F0 ||
        done_cnt != 1) begin
      fails++;
      $display("FAIL repeat_once: frames %0d done %0d first %h required 1 1 020bf0f0",
               frames.size(), done_cnt,
               frames.size() > 0 ? frames[0] : 32'h0);
    end
    tests++;
    if (mosi_err != 0) begin
      fails++;
      $display("FAIL mosi_idle: got %0d cycles required 0", mosi_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_grant();
    test_dreq();
    test_back_to_back();
    test_reset_mid();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vol_sci_writer.md
VOL_SCI_WRITER -- requirements
Module: vol_sci_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, CLK cycles per SCLK half-period (range 2..255).
REQ-002 SHALL have parameter SCI_ADDR, default 8'h0B, target SCI register (VS10xx SCI_VOL).
REQ-003 SHALL have port CLK  in  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RSTN  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port VOL  in  16  requested volume from the volume-setting logic (left byte [15:8], right byte [7:0]); asynchronous to CLK.
REQ-006 SHALL have port BUS_GNT  in  1  SCI bus grant from the player's SCI arbiter.
REQ-007 SHALL have port DREQ  in  1  decoder ready; high means the decoder accepts an SCI command.
REQ-008 SHALL have port BUS_REQ  out  1  SCI bus request, held until the transfer ends.
REQ-009 SHALL have port XCS  out  1  SCI chip select, active-low.
REQ-010 SHALL have port SCLK  out  1  SCI serial clock, idle low.
REQ-011 SHALL have port MOSI  out  1  SCI serial data, MSB first.
REQ-012 SHALL have port BUSY  out  1  high from leaving IDLE until return to IDLE.
REQ-013 SHALL have port DONE  out  1  one-CLK pulse when a write completes.

Function
REQ-014 SHALL pass VOL through a two-flop synchronizer (s1, s2) and treat s2 as valid only when s2 == s1 for the current cycle.
REQ-015 SHALL keep register LAST (reset 16'h0000); a valid s2 != LAST while in IDLE starts a transfer.
REQ-016 SHALL use FSM states IDLE -> REQ -> WAIT_DREQ -> SHIFT -> HOLD -> IDLE.
REQ-017 REQ: BUS_REQ=1; advance on BUS_GNT=1; wait indefinitely otherwise.
REQ-018 WAIT_DREQ: advance when DREQ=1; on entry, latch FRAME = {8'h02, SCI_ADDR, s2} and set LAST = s2.
REQ-019 SHIFT: XCS=0; MOSI = FRAME[31] valid one half-period before the first SCLK rise; the 32 bits are shifted in mode 0 (MOSI changes on SCLK fall, stable at rise); each bit lasts 2*CLK_DIV CLK cycles.
REQ-020 HOLD: after the 32nd SCLK fall, SCLK=0; XCS returns high after one further half-period; stay in HOLD CLK_DIV cycles with XCS=1; then BUS_REQ=0, DONE=1 for one cycle, go to IDLE.
REQ-021 Total XCS-low time SHALL be exactly 65*CLK_DIV CLK cycles.
REQ-022 VOL changing during a transfer SHALL NOT alter FRAME; if the new valid value != LAST at return to IDLE, a new transfer SHALL start the next cycle.
REQ-023 BUS_GNT and DREQ SHALL be ignored once in SHIFT or HOLD; a frame is never aborted except by reset.
REQ-024 Equal consecutive values SHALL produce no transfer (VOL returning to LAST before latch = no write).
REQ-025 MOSI SHALL be 0 whenever XCS=1.

Reset
REQ-026 RSTN low SHALL immediately force: state IDLE, XCS=1, SCLK=0, MOSI=0, BUS_REQ=0, BUSY=0, DONE=0, LAST=16'h0000, s1=s2=0, divider and bit counter 0.
REQ-027 Reset asserted mid-frame SHALL raise XCS in the same instant (truncated frame, no DONE).
REQ-028 After release, a VOL of 16'h0000 SHALL cause no transfer.

Structure
REQ-029 Shared package vs_pkg SHALL hold SCI_OP_WRITE=8'h02, SCI_OP_READ=8'h03, SCI_REG_VOL=8'h0B and the FSM state enum.
REQ-030 SCLK divider plus 32-bit shift register plus bit counter SHALL be one sub-module sci_shift32 (start in; done, SCLK, MOSI out); the FSM, synchronizer and LAST live in vol_sci_writer.

Verification
REQ-031 After reset, set VOL=16'h1010, BUS_GNT=1, DREQ=1 -> one frame 0x020B1010, XCS low 260 CLK (CLK_DIV=4), DONE pulse, LAST=16'h1010.
REQ-032 Hold BUS_GNT=0 for 100 cycles after a VOL change -> BUS_REQ=1, XCS=1 throughout; frame starts after grant.
REQ-033 DREQ=0 at grant, high 50 cycles later -> SHIFT starts only after DREQ rises; dropping DREQ mid-frame does not stall SCLK.
REQ-034 Change VOL 16'h1010 -> 16'h2020 during SHIFT -> first frame carries 1010, second frame 0x020B2020 starts the cycle after return to IDLE.
REQ-035 Assert RSTN=0 at bit 12 -> XCS=1, SCLK=0 immediately, no DONE; after release with VOL=16'h0000, no frame.
REQ-036 VOL=16'hF0F0 then back to 16'hF0F0 after completion -> exactly one frame.
